// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (A, read-only) and data (B, read/write).
// Optional MEM_ARB_ROUND_ROBIN_EN swaps the B-priority starvation guard for round-robin tie-breaking.
//
// state   | meaning
// IDLE    | arbitrating between A and B
// SERVE_A | port A access in flight downstream
// SERVE_B | port B access in flight downstream
module mem_port_arbiter #(
    parameter int unsigned A_MAX_WAIT = 4,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              read_a,
    input  logic [ADDR_W-1:0] address_a,
    output logic              resp_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              read_b,
    input  logic              write_b,
    input  logic [1:0]        wmask_b,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              resp_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        mem_wmask,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;

    state_t            state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [1:0]        mem_wmask_q, mem_wmask_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              req_a, req_b, grant_a, grant_b;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_grant_q, last_grant_d;   // 0 = A, 1 = B
`else
    logic [3:0]        wait_cnt_q, wait_cnt_d;
`endif

    always_comb begin
        state_d       = state_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_wmask_d   = mem_wmask_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        req_a         = read_a;
        req_b         = read_b | write_b;
        grant_a       = 1'b0;
        grant_b       = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_d  = last_grant_q;
`else
        wait_cnt_d    = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_a && req_b) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    grant_a = last_grant_q;
                    grant_b = ~last_grant_q;
`else
                    grant_a = (32'(wait_cnt_q) >= A_MAX_WAIT);
                    grant_b = ~grant_a;
`endif
                end else begin
                    grant_a = req_a;
                    grant_b = req_b;
                end
                if (grant_a) begin
                    state_d       = SERVE_A;
                    mem_read_d    = 1'b1;
                    mem_write_d   = 1'b0;
                    mem_wmask_d   = 2'b11;
                    mem_address_d = address_a;
                    mem_wdata_d   = '0;
                end else if (grant_b) begin
                    // read+write together resolves to a write
                    state_d       = SERVE_B;
                    mem_read_d    = ~write_b;
                    mem_write_d   = write_b;
                    mem_wmask_d   = wmask_b;
                    mem_address_d = address_b;
                    mem_wdata_d   = wdata_b;
                end
            end
            SERVE_A, SERVE_B: begin
                if (mem_resp) begin
                    state_d     = IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (grant_a) last_grant_d = 1'b0;
        if (grant_b) last_grant_d = 1'b1;
`else
        if (grant_a) begin
            wait_cnt_d = 4'd0;
        end else if (grant_b && req_a && wait_cnt_q != 4'hF) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_wmask_q   <= 2'b00;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q  <= 1'b0;
`else
            wait_cnt_q    <= 4'd0;
`endif
        end else begin
            state_q       <= state_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_wmask_q   <= mem_wmask_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q  <= last_grant_d;
`else
            wait_cnt_q    <= wait_cnt_d;
`endif
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_wmask   = mem_wmask_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign resp_a      = (state_q == SERVE_A) & mem_resp;
    assign resp_b      = (state_q == SERVE_B) & mem_resp;
    assign rdata_a     = mem_rdata;
    assign rdata_b     = mem_rdata;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios, then random traffic
// against a transaction-level arbitration model (honours MEM_ARB_ROUND_ROBIN_EN).
module tb_mem_port_arbiter;

    localparam int unsigned A_MAX_WAIT = 4;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        read_a = 1'b0, read_b = 1'b0, write_b = 1'b0, mem_resp = 1'b0;
    logic [1:0]  wmask_b = 2'b00;
    logic [15:0] address_a = '0, address_b = '0, wdata_b = '0, mem_rdata = '0;
    logic        resp_a, resp_b, mem_read, mem_write, busy;
    logic [15:0] rdata_a, rdata_b, mem_address, mem_wdata;
    logic [1:0]  mem_wmask;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.A_MAX_WAIT(A_MAX_WAIT), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
        .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b),
        .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        read_a = 1'b0; read_b = 1'b0; write_b = 1'b0; mem_resp = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_mem_read"}, mem_read, 0);
        check_eq({tag, "_mem_write"}, mem_write, 0);
        check_eq({tag, "_mem_wmask"}, mem_wmask, 0);
        check_eq({tag, "_mem_address"}, mem_address, 0);
        check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
        check_eq({tag, "_resp_a"}, resp_a, 0);
        check_eq({tag, "_resp_b"}, resp_b, 0);
    endtask

    // random-phase model state
    bit          m_busy, m_owner_b, m_wr, m_last_b, win_b;
    int unsigned m_wait;
    logic [15:0] m_addr, m_wdata;
    logic [1:0]  m_mask;
    int          lat;
    bit          a_pend, b_pend;
    logic [1:0]  b_op;
    int          grants[5];
    int          exp_g[5];
    int          ngr;
    bit          exp_busy;

    initial begin
        // reset values
        reset_n = 1'b0;
        step();
        step();
        check_all_zero("reset");
        reset_n = 1'b1;

        // A read, response on third mem_read cycle
        read_a = 1'b1; address_a = 16'h0040;
        step();
        check_eq("a_rd_mem_read1", mem_read, 1);
        check_eq("a_rd_addr", mem_address, 16'h0040);
        check_eq("a_rd_wmask", mem_wmask, 2'b11);
        check_eq("a_rd_wdata", mem_wdata, 0);
        check_eq("a_rd_busy", busy, 1);
        step();
        check_eq("a_rd_mem_read2", mem_read, 1);
        check_eq("a_rd_resp_early", resp_a, 0);
        step();
        check_eq("a_rd_mem_read3", mem_read, 1);
        mem_resp = 1'b1; mem_rdata = 16'h1234;
        #1;
        check_eq("a_rd_resp_a", resp_a, 1);
        check_eq("a_rd_rdata_a", rdata_a, 16'h1234);
        check_eq("a_rd_resp_b", resp_b, 0);
        step();
        mem_resp = 1'b0; read_a = 1'b0;
        #1;
        check_eq("a_rd_done_read", mem_read, 0);
        check_eq("a_rd_done_busy", busy, 0);
        check_eq("a_rd_done_resp", resp_a, 0);

        // B write, inputs disturbed mid-access
        write_b = 1'b1; address_b = 16'h0100; wdata_b = 16'hBEEF; wmask_b = 2'b01;
        step();
        check_eq("b_wr_mem_write", mem_write, 1);
        check_eq("b_wr_mem_read", mem_read, 0);
        check_eq("b_wr_wmask", mem_wmask, 2'b01);
        check_eq("b_wr_wdata", mem_wdata, 16'hBEEF);
        check_eq("b_wr_addr", mem_address, 16'h0100);
        address_b = 16'hFFFF; wdata_b = 16'hFFFF;
        step();
        check_eq("b_wr_hold_addr", mem_address, 16'h0100);
        check_eq("b_wr_hold_wdata", mem_wdata, 16'hBEEF);
        mem_resp = 1'b1;
        #1;
        check_eq("b_wr_resp_b", resp_b, 1);
        check_eq("b_wr_resp_a", resp_a, 0);
        step();
        mem_resp = 1'b0; write_b = 1'b0;
        check_eq("b_wr_idle_busy", busy, 0);
        check_eq("b_wr_idle_write", mem_write, 0);

        // read_b + write_b together -> write
        read_b = 1'b1; write_b = 1'b1; address_b = 16'h0200;
        step();
        check_eq("b_rw_mem_write", mem_write, 1);
        check_eq("b_rw_mem_read", mem_read, 0);
        check_eq("b_rw_addr", mem_address, 16'h0200);
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0; read_b = 1'b0; write_b = 1'b0;

        // held contention: grant order
        do_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_g = '{1, 0, 1, 0, 1};
`else
        exp_g = '{1, 1, 1, 1, 0};
`endif
        read_a = 1'b1; address_a = 16'h0A0A;
        read_b = 1'b1; address_b = 16'h0B0B;
        ngr = 0; exp_busy = 1'b1;
        for (int c = 0; c < 40 && ngr < 5; c++) begin
            step();
            mem_resp = 1'b0;
            check_eq("arb_busy_alt", busy, exp_busy);
            exp_busy = !exp_busy;
            if (busy) begin
                grants[ngr] = (mem_address == 16'h0A0A) ? 0 : 1;
                ngr++;
                mem_resp = 1'b1;
            end
        end
        check_eq("arb_grant_count", ngr, 5);
        for (int i = 0; i < 5; i++) check_eq($sformatf("arb_grant%0d", i), grants[i], exp_g[i]);
        step();
        mem_resp = 1'b0; read_a = 1'b0; read_b = 1'b0;

        // reset mid SERVE_A, stale response ignored
        step();
        read_a = 1'b1; address_a = 16'h0040;
        step();
        check_eq("rst_mid_busy", busy, 1);
        reset_n = 1'b0; read_a = 1'b0;
        step();
        reset_n = 1'b1;
        check_all_zero("rst_mid");
        mem_resp = 1'b1;
        #1;
        check_eq("rst_mid_stale_resp_a", resp_a, 0);
        step();
        check_eq("rst_mid_stale_busy", busy, 0);
        mem_resp = 1'b0;

        // random traffic vs model
        do_reset();
        m_busy = 0; m_owner_b = 0; m_wr = 0; m_last_b = 0; m_wait = 0;
        m_addr = '0; m_wdata = '0; m_mask = '0; lat = 0;
        a_pend = 0; b_pend = 0; b_op = 2'b01;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check_eq("rnd_busy", busy, m_busy);
            check_eq("rnd_mem_read", mem_read, m_busy && !m_wr);
            check_eq("rnd_mem_write", mem_write, m_busy && m_wr);
            check_eq("rnd_mem_address", mem_address, m_addr);
            check_eq("rnd_mem_wdata", mem_wdata, m_wdata);
            check_eq("rnd_mem_wmask", mem_wmask, m_mask);
            if (!a_pend && $urandom_range(0, 2) == 0) begin
                a_pend = 1; address_a = 16'($urandom);
            end
            if (!b_pend && $urandom_range(0, 2) == 0) begin
                b_pend = 1; b_op = 2'($urandom_range(1, 3));
                address_b = 16'($urandom); wdata_b = 16'($urandom); wmask_b = 2'($urandom);
            end
            read_a  = a_pend;
            read_b  = b_pend && b_op[0];
            write_b = b_pend && b_op[1];
            mem_rdata = 16'($urandom);
            if (m_busy) begin
                mem_resp = (lat == 0);
                if (lat > 0) lat--;
            end else begin
                mem_resp = ($urandom_range(0, 7) == 0);
            end
            #1;
            check_eq("rnd_resp_a", resp_a, m_busy && !m_owner_b && mem_resp);
            check_eq("rnd_resp_b", resp_b, m_busy && m_owner_b && mem_resp);
            if (m_busy && mem_resp) begin
                check_eq("rnd_rdata", m_owner_b ? rdata_b : rdata_a, mem_rdata);
                m_busy = 0;
                if (m_owner_b) b_pend = 0; else a_pend = 0;
            end else if (!m_busy && (a_pend || b_pend)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                win_b = (a_pend && b_pend) ? !m_last_b : b_pend;
`else
                win_b = (a_pend && b_pend) ? (m_wait < A_MAX_WAIT) : b_pend;
                if (!win_b) m_wait = 0;
                else if (a_pend) m_wait = (m_wait >= 15) ? 15 : m_wait + 1;
`endif
                m_last_b  = win_b;
                m_busy    = 1;
                m_owner_b = win_b;
                if (win_b) begin
                    m_wr = b_op[1]; m_addr = address_b; m_wdata = wdata_b; m_mask = wmask_b;
                end else begin
                    m_wr = 0; m_addr = address_a; m_wdata = '0; m_mask = 2'b11;
                end
                lat = $urandom_range(0, 3);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
